// File: rtl/pc_unit_pkg.sv
// Shared types for the fetch-stage program-counter unit.
// Holds default widths, the next-PC select encoding and the address type.
package pc_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INC    = 4;

    typedef logic [DEF_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_REDIR,
        SEL_RET,
        SEL_HOLD
    } next_sel_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the PC unit and its neighbours.
// master: hazard/branch side drives stall, redirect, call, ret and
// reads pc, pc_plus and RAS status. slave: the PC unit itself.
interface pc_unit_if #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_err;

    modport master (
        output stall, redirect_valid, redirect_addr, call, ret,
        input  pc, pc_plus, ras_count, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_addr, call, ret,
        output pc, pc_plus, ras_count, ras_empty, ras_full, ras_err
    );

endinterface

// File: rtl/pc_unit_ras.sv
// Circular return-address stack with saturating count and sticky error.
// Ports: clk, rst_n, push/pop strobes, push_data, top (newest entry),
// count (valid entries), err (pop-when-empty or push-when-full seen).
module ras_stack #(
    parameter  int ADDR_W    = 32,
    parameter  int RAS_DEPTH = 4,
    localparam int PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1,
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              err
);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [CNT_W-1:0]  cnt_r;
    logic              err_r;
    logic              full;
    logic              empty;

    // ptr_r is the next free slot; the newest entry sits one below it.
    // Wrapping the pointer lets a push when full overwrite the oldest.
    always_comb begin
        ptr_inc = ptr_r + PTR_W'(1);
        ptr_dec = ptr_r - PTR_W'(1);
        if (ptr_r == PTR_W'(RAS_DEPTH - 1))
            ptr_inc = '0;
        if (ptr_r == '0)
            ptr_dec = PTR_W'(RAS_DEPTH - 1);
    end

    assign full  = (cnt_r == CNT_W'(RAS_DEPTH));
    assign empty = (cnt_r == '0);

    // Entry contents carry no reset value.
    always_ff @(posedge clk) begin
        if (push && rst_n)
            mem[ptr_r] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
            cnt_r <= '0;
            err_r <= 1'b0;
        end else if (push) begin
            ptr_r <= ptr_inc;
            if (full)
                err_r <= 1'b1;
            else
                cnt_r <= cnt_r + CNT_W'(1);
        end else if (pop) begin
            if (empty) begin
                err_r <= 1'b1;
            end else begin
                ptr_r <= ptr_dec;
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    assign top   = mem[ptr_dec];
    assign count = cnt_r;
    assign err   = err_r;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, stall, redirect, RAS.
// Ports: clk, rst_n, and bus (slave) carrying control in, pc/status out.
module pc_unit
    import pc_pkg::*;
#(
    parameter  int                ADDR_W    = DEF_ADDR_W,
    parameter  logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter  int                INC       = DEF_INC,
    parameter  int                RAS_DEPTH = 4,
    localparam int                CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    pc_unit_if.slave bus
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_plus;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ras_top;
    logic [CNT_W-1:0]  ras_cnt;
    logic              ras_empty;
    logic              push;
    logic              pop;
    next_sel_t         sel;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_plus = pc_r + ADDR_W'(INC);

    // Redirect outranks stall, stall outranks ret, so push and pop
    // can never coincide.
    assign push = bus.redirect_valid & bus.call;
    assign pop  = ~bus.redirect_valid & ~bus.stall & bus.ret;

    assign ras_empty = (ras_cnt == '0);

    always_comb begin
        sel = SEL_SEQ;
        unique case (1'b1)
            bus.redirect_valid:           sel = SEL_REDIR;
            (!bus.redirect_valid &&
             bus.stall):                  sel = SEL_HOLD;
            (pop && !ras_empty):          sel = SEL_RET;
            default:                      sel = SEL_SEQ;
        endcase
    end

    always_comb begin
        pc_next = pc_plus;
        unique case (sel)
            SEL_REDIR: pc_next = bus.redirect_addr;
            SEL_HOLD:  pc_next = pc_r;
            SEL_RET:   pc_next = ras_top;
            SEL_SEQ:   pc_next = pc_plus;
            default:   pc_next = pc_plus;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_r <= RESET_VEC;
        else
            pc_r <= pc_next;
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .count     (ras_cnt),
        .err       (bus.ras_err)
    );

    assign bus.pc        = pc_r;
    assign bus.pc_plus   = pc_plus;
    assign bus.ras_count = ras_cnt;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, stall/redirect, call/return,
// RAS overflow/underflow and address wrap with hand-computed values.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int    RAS_DEPTH = 4;
    localparam addr_t RV        = 32'h0040_0000;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    pc_unit_if #(.ADDR_W(32), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_unit #(
        .ADDR_W    (32),
        .RESET_VEC (RV),
        .INC       (4),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.call           = 1'b0;
        bus.ret            = 1'b0;
    endtask

    // Inputs change and outputs are sampled 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(input addr_t a);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = a;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b1;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_pc_async", bus.pc, RV);
        chk("reset_count", 32'(bus.ras_count), 32'd0);
        chk("reset_err", 32'(bus.ras_err), 32'd0);
        chk("reset_empty", 32'(bus.ras_empty), 32'd1);
        chk("reset_full", 32'(bus.ras_full), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("seq_1", bus.pc, 32'h0040_0004);
        step();
        chk("seq_2", bus.pc, 32'h0040_0008);
        step();
        chk("seq_3", bus.pc, 32'h0040_000C);
    endtask

    task automatic test_stall_redirect();
        redirect_to(32'h100);
        chk("redir_100", bus.pc, 32'h100);
        bus.stall = 1'b1;
        step();
        chk("stall_1", bus.pc, 32'h100);
        bus.ret  = 1'b1;
        bus.call = 1'b1;
        step();
        chk("stall_2_callret_ignored", bus.pc, 32'h100);
        chk("stall_count", 32'(bus.ras_count), 32'd0);
        chk("stall_err", 32'(bus.ras_err), 32'd0);
        bus.call           = 1'b0;
        bus.ret            = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h200;
        step();
        idle();
        chk("stall_redir_200", bus.pc, 32'h200);
    endtask

    task automatic test_call_return();
        redirect_to(32'h100);
        bus.call = 1'b1;
        redirect_to(32'h800);
        chk("call_pc", bus.pc, 32'h800);
        chk("call_count", 32'(bus.ras_count), 32'd1);
        chk("call_empty", 32'(bus.ras_empty), 32'd0);
        step();
        step();
        chk("call_seq_pc", bus.pc, 32'h808);
        chk("pc_plus_comb", bus.pc_plus, 32'h80C);
        bus.call = 1'b1;
        step();
        bus.call = 1'b0;
        chk("call_no_redir_pc", bus.pc, 32'h80C);
        chk("call_no_redir_cnt", 32'(bus.ras_count), 32'd1);
        bus.ret = 1'b1;
        step();
        idle();
        chk("ret_pc", bus.pc, 32'h104);
        chk("ret_count", 32'(bus.ras_count), 32'd0);
        chk("ret_empty", 32'(bus.ras_empty), 32'd1);
        chk("ret_err", 32'(bus.ras_err), 32'd0);
    endtask

    task automatic test_overflow();
        addr_t tgt [5];
        addr_t exp_ret [4];
        tgt = '{32'h2000, 32'h3000, 32'h4000, 32'h5000, 32'h6000};
        exp_ret = '{32'h5004, 32'h4004, 32'h3004, 32'h2004};
        do_reset();
        redirect_to(32'h1000);
        for (int i = 0; i < 5; i++) begin
            bus.call = 1'b1;
            redirect_to(tgt[i]);
            chk("ovf_call_pc", bus.pc, tgt[i]);
            if (i == 3) begin
                chk("ovf_full_4", 32'(bus.ras_full), 32'd1);
                chk("ovf_err_4", 32'(bus.ras_err), 32'd0);
            end
        end
        chk("ovf_full", 32'(bus.ras_full), 32'd1);
        chk("ovf_count", 32'(bus.ras_count), 32'd4);
        chk("ovf_err", 32'(bus.ras_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.ret = 1'b1;
            step();
            idle();
            chk("ovf_ret_pc", bus.pc, exp_ret[i]);
            chk("ovf_ret_cnt", 32'(bus.ras_count), 32'(3 - i));
        end
        chk("ovf_err_sticky", 32'(bus.ras_err), 32'd1);
    endtask

    task automatic test_underflow();
        do_reset();
        chk("udf_err_cleared", 32'(bus.ras_err), 32'd0);
        redirect_to(32'h300);
        bus.ret = 1'b1;
        step();
        idle();
        chk("udf_pc", bus.pc, 32'h304);
        chk("udf_err", 32'(bus.ras_err), 32'd1);
        chk("udf_count", 32'(bus.ras_count), 32'd0);
        step();
        redirect_to(32'h10);
        chk("udf_err_sticky", 32'(bus.ras_err), 32'd1);
        do_reset();
        chk("udf_err_reset", 32'(bus.ras_err), 32'd0);
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        chk("wrap_pc_plus", bus.pc_plus, 32'h0);
        step();
        chk("wrap_pc", bus.pc, 32'h0);
        bus.call = 1'b1;
        redirect_to(32'h500);
        chk("wrap_call_cnt", 32'(bus.ras_count), 32'd1);
        bus.ret = 1'b1;
        redirect_to(32'h40);
        chk("ret_redir_pc", bus.pc, 32'h40);
        chk("ret_redir_cnt", 32'(bus.ras_count), 32'd1);
        bus.ret   = 1'b1;
        bus.stall = 1'b1;
        step();
        idle();
        chk("ret_stall_pc", bus.pc, 32'h40);
        chk("ret_stall_cnt", 32'(bus.ras_count), 32'd1);
        bus.ret = 1'b1;
        step();
        idle();
        chk("wrap_ret_pc", bus.pc, 32'h4);
    endtask

    // Reset asserted before an edge that would have pushed.
    task automatic test_reset_mid_call();
        bus.call = 1'b1;
        redirect_to(32'h700);
        chk("mid_pre_cnt", 32'(bus.ras_count), 32'd1);
        bus.call           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h900;
        #2;
        rst_n = 1'b0;
        step();
        chk("mid_call_pc", bus.pc, RV);
        chk("mid_call_cnt", 32'(bus.ras_count), 32'd0);
        idle();
        rst_n = 1'b1;
        step();
        chk("mid_call_release", bus.pc, RV + 32'd4);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        idle();
        test_reset();
        test_stall_redirect();
        test_call_return();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_mid_call();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS fetch stage. It holds the current fetch address and advances it by a fixed increment each cycle. It accepts stall requests from the hazard unit and redirects from branch/jump resolution. It also keeps a small return-address stack (RAS) so call/return pairs resolve without a full redirect. Its output feeds instruction memory and the IF/ID pipeline register.

## Interface
Parameters:
- ADDR_W, 32: address width in bits
- RESET_VEC, 0: value of `pc` after reset (ADDR_W bits)
- INC, 4: sequential increment
- RAS_DEPTH, 4: return-address stack entries, ≥2

Ports:
- clk  in  1  clock, rising edge active
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold `pc` and the RAS this cycle
- redirect_valid  in  1  load `redirect_addr` next cycle
- redirect_addr  in  ADDR_W  branch/jump target
- call  in  1  push `pc_plus` onto the RAS; only honoured together with `redirect_valid`
- ret  in  1  pop the RAS top into `pc`
- pc  out  ADDR_W  current fetch address (registered)
- pc_plus  out  ADDR_W  `pc + INC`, combinational
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries (registered)
- ras_empty  out  1  `ras_count == 0`
- ras_full  out  1  `ras_count == RAS_DEPTH`
- ras_err  out  1  sticky; set on pop-when-empty or push-when-full

## Operation
The next-PC select is evaluated each cycle in this priority order:
1. redirect_valid=1: `pc <= redirect_addr`, even if `stall`=1.
   - If `call`=1 as well: push `pc_plus`.
   - `ret` is ignored (no pop).
2. stall=1: hold `pc`; no RAS change. `call`/`ret` are ignored.
3. ret=1:
   - RAS not empty: `pc <= RAS top`, pop, `ras_count`−1.
   - RAS empty: `pc <= pc_plus`, no pop, set `ras_err`.
4. Otherwise: `pc <= pc_plus`.

`call` without `redirect_valid` has no effect.

Arithmetic:
- `pc_plus` wraps modulo 2^ADDR_W (e.g. all-ones minus 3, +4 → 0).
- Addresses are not aligned or checked.

RAS:
- Circular LIFO with top pointer and saturating count.
- Push when full overwrites the oldest entry. Count stays at RAS_DEPTH and `ras_err` is set.
- The pop after a full-overflow returns the newest entry (LIFO order is kept for the last RAS_DEPTH pushes).

Reset values: `pc`=RESET_VEC, `ras_count`=0, `ras_err`=0, RAS pointer=0. Entry contents are don't-care.

## Timing
- All state updates on the rising clk edge. `pc` reflects a select one cycle after it is presented.
- Redirect latency: 1 cycle (target visible on `pc` at the next edge).
- `ras_empty`/`ras_full` are decoded from the registered `ras_count`, so they have no combinational path from the inputs.
- `pc_plus` is combinational from `pc` only.
- `rst_n` falling forces the reset values immediately, regardless of clk. This includes mid-stall and mid-call: a push in flight is discarded.
- Release of `rst_n` is synchronous to clk (external synchroniser). The first edge after release computes from RESET_VEC.
- Push and pop never occur in the same cycle (priority order excludes it).

## Structure
- Package `pc_pkg`:
  - default ADDR_W, INC
  - `next_sel_t` enum: SEL_SEQ, SEL_REDIR, SEL_RET, SEL_HOLD
  - `addr_t` typedef
- Sub-module `ras_stack`:
  - parameters ADDR_W, RAS_DEPTH
  - ports clk, rst_n, push, pop, push_data, top, count, err
  - owns the circular buffer, pointer, count and sticky error
- `pc_unit` holds the select logic and the PC register.

## Test plan
- Reset: with `rst_n`=0 asynchronously mid-cycle, RESET_VEC=0x0040_0000 → `pc`=0x0040_0000 immediately; 3 free-running edges → 0x0040_0004, 0x0040_0008, 0x0040_000C.
- Stall vs redirect: `pc`=0x100, `stall`=1 for 2 cycles → `pc` stays 0x100. Then `stall`=1 with `redirect_valid`=1, addr 0x200 → `pc`=0x200 next cycle.
- Call/return: at `pc`=0x100 assert `call`+`redirect_valid` with target 0x800 → `pc`=0x800, `ras_count`=1. Two sequential cycles → `pc`=0x808. Then `ret` → `pc`=0x104, `ras_count`=0, `ras_empty`=1.
- Overflow: with RAS_DEPTH=4, 5 calls pushing A..E → `ras_full`=1, `ras_err`=1. Then 4 rets → targets E, D, C, B.
- Underflow: `ret` on an empty RAS at `pc`=0x300 → `pc`=0x304, `ras_err`=1 and stays set until reset.
- Wrap: `pc`=0xFFFF_FFFC, no stall → `pc`=0x0000_0000. `ret` together with `redirect_valid` to 0x40 → `pc`=0x40, `ras_count` unchanged.
